sensor_bus_arbiter: RTL
=======================

// Module: sensor_bus_arbiter
// PURPOSE
//  Shares the single SCLK/SDAT pin pair between the I2C master (EEPROM) and the g-sensor SPI master.
//  Replaces the software-driven clock-select PIO with request/grant arbitration.
//  Inserts a bus-idle turnaround between owners and drives the pin-side clock, data and output enable.
//  Sits in the top level between the SOPC peripheral pins and I2C_SCLK/I2C_SDAT.
// PARAMETERS
//  GUARD_CYCLES  4     clk_50 cycles of bus-idle turnaround before a grant and after a release (>=1)
//  MAX_HOLD      4096  max grant length in cycles before forced revoke (used only with the macro)
// PORTS
//  clk_50        in   1  system clock
//  reset_n       in   1  asynchronous, active-low reset
//  i2c_req       in   1  I2C master requests the bus (level, held for the whole transfer)
//  i2c_gnt       out  1  I2C master owns the bus
//  i2c_scl       in   1  I2C clock from the master
//  i2c_sda_o     in   1  I2C data out
//  i2c_sda_oe    in   1  I2C data output enable
//  spi_req       in   1  SPI master requests the bus
//  spi_gnt       out  1  SPI master owns the bus
//  spi_sclk      in   1  SPI clock from the master
//  spi_sdio_o    in   1  SPI data out
//  spi_sdio_oe   in   1  SPI data output enable
//  bus_sclk      out  1  drives the I2C_SCLK pin
//  bus_sda_o     out  1  pin data
//  bus_sda_oe    out  1  pin output enable (the pin tristates when 0)
//  owner         out  2  00 none, 01 I2C, 10 SPI (11 never driven)
//  timeout_evt   out  1  1-cycle pulse on a forced revoke
// BEHAVIOUR
//  FSM states: IDLE, PRE_GUARD, GRANT, POST_GUARD. Registered state, owner and guard counter.
//  Reset: state=IDLE, gnts=0, owner=00, bus_sclk=1, bus_sda_o=1, bus_sda_oe=0, timeout_evt=0.
//   - last_served resets to SPI, so the first tie goes to I2C.
//  IDLE: if any request is high, select the winner, load the counter with GUARD_CYCLES and go to PRE_GUARD.
//   - Tie: round-robin, the side not in last_served wins.
//  PRE_GUARD: bus idle (sclk=1, oe=0), owner=00; the counter decrements each cycle.
//   - Counter reaches 0 with the winner's req still high: go to GRANT, gnt=1, owner set, last_served updated.
//   - Winner's req drops during PRE_GUARD: return to IDLE next cycle; no grant is issued.
//  Latency: req sampled high in IDLE at edge N -> gnt high after edge N+GUARD_CYCLES+1.
//  GRANT: bus_sclk, bus_sda_o and bus_sda_oe are muxed combinationally from the owner's inputs.
//   - The mux select comes only from the registered owner (glitch-free).
//   - The other requester's req is ignored (it waits).
//  Release: the owner's req low while in GRANT.
//   - gnt and owner clear on the next edge; go to POST_GUARD (GUARD_CYCLES cycles, bus idle), then IDLE.
//  Back-to-back: both requesting continuously alternate owners, separated by 2*GUARD_CYCLES+1 idle cycles.
//  Guard counter width is $clog2(GUARD_CYCLES+1); it never wraps (it saturates at 0).
//  Async reset mid-grant: bus immediately returns to idle levels and both gnts drop.
// CONFIGURATION
//  Macro SENSOR_BUS_ARB_TIMEOUT_EN.
//  Defined:
//   - A hold counter runs in GRANT.
//   - At MAX_HOLD cycles: gnt drops, timeout_evt pulses for 1 cycle, go to POST_GUARD.
//   - The timed-out side is locked out until its req is seen low for at least 1 cycle.
//   - The other requester wins the next arbitration if requesting.
//  Undefined: no hold counter and no lockout; timeout_evt is tied 0; a grant is held indefinitely.
// STRUCTURE
//  Shared include sensor_bus_defs.vh holds:
//   - FSM state encodings;
//   - OWNER_NONE/OWNER_I2C/OWNER_SPI (2-bit);
//   - idle bus levels.
//  One sub-module, bus_turnaround_timer: a loadable down-counter with a done flag, used for both guard phases.
//  Arbiter FSM, round-robin flag, output mux and optional hold counter live in the top module.
// TESTING (GUARD_CYCLES=4, MAX_HOLD=64 for the bench)
//  1. Reset then i2c_req=1 at cycle 10.
//     -> i2c_gnt=1 at cycle 15, owner=01, bus_sclk follows i2c_scl; before that bus_sda_oe=0 and bus_sclk=1.
//  2. i2c_req and spi_req rise on the same edge after reset.
//     -> I2C granted first; after i2c_req drops: 4 idle cycles, IDLE, 4 more, then spi_gnt=1; the next tie goes to I2C.
//  3. spi_req pulses high for 2 cycles only.
//     -> no grant, FSM back to IDLE, owner stays 00, bus never leaves idle levels.
//  4. spi owns the bus; i2c_req rises mid-transfer.
//     -> i2c_gnt stays 0 until spi_req drops + 4 + 1 + 4 cycles; no cycle with both gnts high (assertion).
//  5. reset_n low while spi_gnt=1.
//     -> outputs reach reset values without a clock edge; after release, a fresh request sees the full 4-cycle guard.
//  6. (SENSOR_BUS_ARB_TIMEOUT_EN) spi_req held high 200 cycles.
//     -> revoke after 64 cycles, timeout_evt pulses once, no re-grant to SPI until spi_req toggles low.
//     -> without the macro, spi_gnt is held all 200 cycles.

Source files
------------

// File: rtl/sensor_bus_arbiter_pkg.sv
// Shared definitions for the sensor bus arbiter: FSM state encodings, owner codes and idle pin levels.
package sensor_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_PRE_GUARD  = 2'd1,
    ST_GRANT      = 2'd2,
    ST_POST_GUARD = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'b00,
    OWNER_I2C  = 2'b01,
    OWNER_SPI  = 2'b10
  } owner_t;

  localparam logic IDLE_SCLK = 1'b1;
  localparam logic IDLE_SDA  = 1'b1;
  localparam logic IDLE_OE   = 1'b0;

  // Request line belonging to a given side; OWNER_NONE never requests.
  function automatic logic req_of(owner_t who, logic i2c_req, logic spi_req);
    case (who)
      OWNER_I2C: return i2c_req;
      OWNER_SPI: return spi_req;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sensor_bus_arbiter_turnaround.sv
// bus_turnaround_timer: loadable saturating down-counter; done flags the last cycle of a guard phase.
module bus_turnaround_timer #(
  parameter int LOAD_VALUE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(LOAD_VALUE + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(LOAD_VALUE);
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // A phase loaded with N lasts exactly N cycles: it ends on the edge where the count leaves 1.
  assign done = (count <= W'(1));

endmodule

// File: rtl/sensor_bus_arbiter.sv
// Request/grant arbiter sharing the SCLK/SDAT pin pair between the I2C and SPI masters.
// Optional grant timeout with lockout is enabled by defining SENSOR_BUS_ARB_TIMEOUT_EN.
module sensor_bus_arbiter #(
  parameter int GUARD_CYCLES = 4,
  parameter int MAX_HOLD     = 4096
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       i2c_req,
  output logic       i2c_gnt,
  input  logic       i2c_scl,
  input  logic       i2c_sda_o,
  input  logic       i2c_sda_oe,
  input  logic       spi_req,
  output logic       spi_gnt,
  input  logic       spi_sclk,
  input  logic       spi_sdio_o,
  input  logic       spi_sdio_oe,
  output logic       bus_sclk,
  output logic       bus_sda_o,
  output logic       bus_sda_oe,
  output logic [1:0] owner,
  output logic       timeout_evt
);

  import sensor_bus_arbiter_pkg::*;

  arb_state_t state, state_nx;
  owner_t     owner_q, owner_nx, winner_q, winner_nx;
  logic       last_spi_q, last_spi_nx;
  logic       guard_load, guard_done;
  logic       lock_i2c, lock_spi, hold_expired;
  logic       elig_i2c, elig_spi, winner_req, owner_req;

  bus_turnaround_timer #(.LOAD_VALUE(GUARD_CYCLES)) u_guard (
    .clk   (clk_50),
    .rst_n (reset_n),
    .load  (guard_load),
    .done  (guard_done)
  );

  assign elig_i2c   = i2c_req & ~lock_i2c;
  assign elig_spi   = spi_req & ~lock_spi;
  assign winner_req = req_of(winner_q, i2c_req, spi_req);
  assign owner_req  = req_of(owner_q, i2c_req, spi_req);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      owner_q    <= OWNER_NONE;
      winner_q   <= OWNER_NONE;
      last_spi_q <= 1'b1;
    end else begin
      state      <= state_nx;
      owner_q    <= owner_nx;
      winner_q   <= winner_nx;
      last_spi_q <= last_spi_nx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner_q;
    winner_nx   = winner_q;
    last_spi_nx = last_spi_q;
    guard_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (elig_i2c || elig_spi) begin
          // On a tie the side that was not served last wins.
          winner_nx  = (elig_i2c && (!elig_spi || last_spi_q)) ? OWNER_I2C : OWNER_SPI;
          guard_load = 1'b1;
          state_nx   = ST_PRE_GUARD;
        end
      end
      ST_PRE_GUARD: begin
        if (!winner_req) begin
          winner_nx = OWNER_NONE;
          state_nx  = ST_IDLE;
        end else if (guard_done) begin
          owner_nx    = winner_q;
          last_spi_nx = (winner_q == OWNER_SPI);
          winner_nx   = OWNER_NONE;
          state_nx    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!owner_req || hold_expired) begin
          owner_nx   = OWNER_NONE;
          guard_load = 1'b1;
          state_nx   = ST_POST_GUARD;
        end
      end
      ST_POST_GUARD: begin
        if (guard_done) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

`ifdef SENSOR_BUS_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_fire, timeout_q;

  assign hold_expired = (state == ST_GRANT) && (hold_cnt == HOLD_W'(MAX_HOLD - 1));
  assign timeout_fire = hold_expired && owner_req;

  // A revoked side stays locked out until its request has been seen low.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
      lock_i2c  <= 1'b0;
      lock_spi  <= 1'b0;
    end else begin
      hold_cnt  <= (state == ST_GRANT) ? hold_cnt + 1'b1 : '0;
      timeout_q <= timeout_fire;
      if (timeout_fire && owner_q == OWNER_I2C) lock_i2c <= 1'b1;
      else if (!i2c_req)                        lock_i2c <= 1'b0;
      if (timeout_fire && owner_q == OWNER_SPI) lock_spi <= 1'b1;
      else if (!spi_req)                        lock_spi <= 1'b0;
    end
  end

  assign timeout_evt = timeout_q;
`else
  assign hold_expired = 1'b0;
  assign lock_i2c     = 1'b0;
  assign lock_spi     = 1'b0;
  assign timeout_evt  = 1'b0;
`endif

  // Pin mux selected only by the registered owner, so it cannot glitch on request changes.
  always_comb begin
    bus_sclk   = IDLE_SCLK;
    bus_sda_o  = IDLE_SDA;
    bus_sda_oe = IDLE_OE;
    case (owner_q)
      OWNER_I2C: begin
        bus_sclk   = i2c_scl;
        bus_sda_o  = i2c_sda_o;
        bus_sda_oe = i2c_sda_oe;
      end
      OWNER_SPI: begin
        bus_sclk   = spi_sclk;
        bus_sda_o  = spi_sdio_o;
        bus_sda_oe = spi_sdio_oe;
      end
      default: ;
    endcase
  end

  assign i2c_gnt = (owner_q == OWNER_I2C);
  assign spi_gnt = (owner_q == OWNER_SPI);
  assign owner   = owner_q;

endmodule
